// File: rtl/div_ctrl.sv
// Sequencer for the shared iterative divider used by the EXE stage for div.w, mod.w, div.wu and mod.wu.
// It captures the operands, runs a radix-2 restoring divide for WIDTH cycles, applies the sign fix-up,
// and then holds the result until EXE hands the instruction on.
module div_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             div_enable,
  input  logic             div_sign,
  input  logic [WIDTH-1:0] div_src1,
  input  logic [WIDTH-1:0] div_src2,
  input  logic             div_accept,
  output logic             div_complete,
  output logic             div_busy,
  output logic [WIDTH-1:0] div_quotient,
  output logic [WIDTH-1:0] div_remainder
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_POST = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;        // dividend shifts out MSB-first, quotient bits shift in
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             qsgn_q, qsgn_d;
  logic             rsgn_q, rsgn_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             complete_q, complete_d;
  logic             busy_q, busy_d;

  logic [WIDTH:0]   r_ext;
  logic [WIDTH:0]   r_sub;
  logic [WIDTH-1:0] src1_abs;
  logic [WIDTH-1:0] src2_abs;

  // Next-state, datapath step and registered-output decisions
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    rem_d      = rem_q;
    qsgn_d     = qsgn_q;
    rsgn_d     = rsgn_q;
    quo_d      = quo_q;
    rmd_d      = rmd_q;
    complete_d = complete_q;

    // A negative operand is stored as its magnitude; the most negative value maps onto itself.
    src1_abs = (div_sign && div_src1[WIDTH-1]) ? -div_src1 : div_src1;
    src2_abs = (div_sign && div_src2[WIDTH-1]) ? -div_src2 : div_src2;
    // The partial remainder is always below the divisor, so one extra bit holds the shifted value.
    r_ext    = {rem_q, dvd_q[WIDTH-1]};
    r_sub    = r_ext - {1'b0, dvs_q};

    case (state_q)
      S_IDLE: begin
        if (div_enable) begin
          dvd_d   = src1_abs;
          dvs_d   = src2_abs;
          qsgn_d  = div_sign & (div_src1[WIDTH-1] ^ div_src2[WIDTH-1]);
          rsgn_d  = div_sign & div_src1[WIDTH-1];
          rem_d   = '0;
          cnt_d   = '0;
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        if (!div_enable) begin
          state_d = S_IDLE;
        end else begin
          if (r_ext >= {1'b0, dvs_q}) begin
            rem_d = r_sub[WIDTH-1:0];
            dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = r_ext[WIDTH-1:0];
            dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = S_POST;
          end
        end
      end
      S_POST: begin
        if (!div_enable) begin
          state_d = S_IDLE;
        end else begin
          quo_d      = qsgn_q ? -dvd_q : dvd_q;
          rmd_d      = rsgn_q ? -rem_q : rem_q;
          complete_d = 1'b1;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        // Leaves on hand-off to MEM or on a pipeline flush.
        if (div_accept || !div_enable) begin
          complete_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: begin
        complete_d = 1'b0;
        state_d    = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      qsgn_q     <= 1'b0;
      rsgn_q     <= 1'b0;
      quo_q      <= '0;
      rmd_q      <= '0;
      complete_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      rem_q      <= rem_d;
      qsgn_q     <= qsgn_d;
      rsgn_q     <= rsgn_d;
      quo_q      <= quo_d;
      rmd_q      <= rmd_d;
      complete_q <= complete_d;
      busy_q     <= busy_d;
    end
  end

  assign div_complete  = complete_q;
  assign div_busy      = busy_q;
  assign div_quotient  = quo_q;
  assign div_remainder = rmd_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: directed corner cases plus random divides, checked against an arithmetic reference model.
module tb_div_ctrl;

  logic        clk;
  logic        resetn;
  logic        div_enable;
  logic        div_sign;
  logic [31:0] div_src1;
  logic [31:0] div_src2;
  logic        div_accept;
  logic        div_complete;
  logic        div_busy;
  logic [31:0] div_quotient;
  logic [31:0] div_remainder;

  int checks;
  int failures;

  div_ctrl #(.WIDTH(32)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .div_enable   (div_enable),
    .div_sign     (div_sign),
    .div_src1     (div_src1),
    .div_src2     (div_src2),
    .div_accept   (div_accept),
    .div_complete (div_complete),
    .div_busy     (div_busy),
    .div_quotient (div_quotient),
    .div_remainder(div_remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: divide magnitudes, divide-by-zero gives all-ones / dividend, then apply the signs.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] q, output logic [31:0] r);
    logic [31:0] ua, ub, uq, ur;
    ua = (s && a[31]) ? -a : a;
    ub = (s && b[31]) ? -b : b;
    if (ub == 32'd0) begin
      uq = 32'hFFFF_FFFF;
      ur = ua;
    end else begin
      uq = ua / ub;
      ur = ua % ub;
    end
    q = (s && (a[31] ^ b[31])) ? -uq : uq;
    r = (s && a[31]) ? -ur : ur;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [31:0] a, input logic [31:0] b, input logic s);
    div_src1   = a;
    div_src2   = b;
    div_sign   = s;
    div_enable = 1'b1;
  endtask

  // Counts clock edges until completion, bounded so a stuck design still reaches the summary.
  task automatic wait_done(output int n);
    n = 0;
    while (!div_complete && n < 80) begin
      step();
      n++;
    end
  endtask

  task automatic finish_op();
    div_accept = 1'b1;
    div_enable = 1'b0;
    step();
    div_accept = 1'b0;
    chk("complete_drop", 32'(div_complete), 32'd0);
    chk("busy_drop", 32'(div_busy), 32'd0);
  endtask

  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s);
    int n;
    logic [31:0] eq, er;
    model(a, b, s, eq, er);
    start(a, b, s);
    wait_done(n);
    chk({tag, "_latency"}, 32'(n), 32'd34);
    chk({tag, "_q"}, div_quotient, eq);
    chk({tag, "_r"}, div_remainder, er);
    finish_op();
  endtask

  initial begin
    int n;
    logic [31:0] a, b, eq, er, hq, hr;
    logic s;
    int sel;

    checks     = 0;
    failures   = 0;
    resetn     = 1'b0;
    div_enable = 1'b0;
    div_sign   = 1'b0;
    div_src1   = '0;
    div_src2   = '0;
    div_accept = 1'b0;

    #2;
    chk("rst_complete", 32'(div_complete), 32'd0);
    chk("rst_busy", 32'(div_busy), 32'd0);
    chk("rst_q", div_quotient, 32'd0);
    chk("rst_r", div_remainder, 32'd0);
    #10 resetn = 1'b1;
    step();

    // Basic unsigned, with busy observed mid-divide
    start(32'd100, 32'd7, 1'b0);
    step();
    chk("busy_iter", 32'(div_busy), 32'd1);
    wait_done(n);
    chk("u100_7_latency", 32'(n + 1), 32'd34);
    chk("u100_7_q", div_quotient, 32'd14);
    chk("u100_7_r", div_remainder, 32'd2);
    finish_op();

    run_div("s_m100_7", -32'sd100, 32'd7, 1'b1);
    run_div("s_100_m7", 32'd100, -32'sd7, 1'b1);
    run_div("u_max_2", 32'hFFFF_FFFF, 32'd2, 1'b0);
    run_div("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_div("u_7_0", 32'd7, 32'd0, 1'b0);
    run_div("s_m7_0", -32'sd7, 32'd0, 1'b1);
    run_div("u_0_5", 32'd0, 32'd5, 1'b0);
    run_div("s_7_0", 32'd7, 32'd0, 1'b1);

    // Held completion, then back-to-back 9/3
    model(32'd50, 32'd6, 1'b0, hq, hr);
    start(32'd50, 32'd6, 1'b0);
    wait_done(n);
    chk("held_latency", 32'(n), 32'd34);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("held_complete", 32'(div_complete), 32'd1);
      chk("held_q", div_quotient, hq);
      chk("held_r", div_remainder, hr);
    end
    div_accept = 1'b1;
    start(32'd9, 32'd3, 1'b0);
    step();
    div_accept = 1'b0;
    chk("b2b_drop", 32'(div_complete), 32'd0);
    wait_done(n);
    chk("b2b_latency", 32'(n), 32'd34);
    chk("b2b_q", div_quotient, 32'd3);
    chk("b2b_r", div_remainder, 32'd0);
    finish_op();

    // Operands change after the start cycle
    a = $urandom;
    b = $urandom_range(1, 1000);
    model(a, b, 1'b0, eq, er);
    start(a, b, 1'b0);
    repeat (5) step();
    div_src1 = ~a;
    div_src2 = b + 32'd3;
    wait_done(n);
    chk("opchg_latency", 32'(n + 5), 32'd34);
    chk("opchg_q", div_quotient, eq);
    chk("opchg_r", div_remainder, er);
    finish_op();
    hq = eq;
    hr = er;

    // Flush mid-iteration: no completion, outputs keep the previous result
    start(32'd1000, 32'd3, 1'b0);
    repeat (10) step();
    div_enable = 1'b0;
    step();
    chk("flush_busy", 32'(div_busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("flush_complete", 32'(div_complete), 32'd0);
    end
    chk("flush_q_kept", div_quotient, hq);
    chk("flush_r_kept", div_remainder, hr);
    run_div("after_flush", 32'd1000, 32'd3, 1'b0);

    // Asynchronous reset mid-iteration
    start(32'd12345, 32'd67, 1'b0);
    repeat (8) step();
    #2 resetn = 1'b0;
    #1;
    chk("arst_busy", 32'(div_busy), 32'd0);
    chk("arst_complete", 32'(div_complete), 32'd0);
    chk("arst_q", div_quotient, 32'd0);
    chk("arst_r", div_remainder, 32'd0);
    div_enable = 1'b0;
    #2 resetn = 1'b1;
    repeat (3) begin
      step();
      chk("post_rst_complete", 32'(div_complete), 32'd0);
    end
    run_div("after_rst", 32'd12345, 32'd67, 1'b0);

    // Random operands with weighted corner divisors
    for (int i = 0; i < 30; i++) begin
      s   = 1'($urandom_range(0, 1));
      a   = $urandom;
      sel = int'($urandom_range(0, 7));
      case (sel)
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFF_FFFF;
        3:       begin a = 32'h8000_0000; b = $urandom; end
        4:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      run_div("rand", a, b, s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
